cpu_core_param: RTL

Parametrised successor to the 8-bit multicycle CPU control unit. It is generalised in data width, register count and PC width, and adds run/step gating, a zero flag, conditional jump, illegal-opcode detection and a retired-instruction counter. It fetches 16-bit instructions from an external combinational instruction memory. The full register file and FSM state are exposed for testbench observation.

---
 rtl/cpu_core_param.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/cpu_core_param.sv
// Parametrised multicycle CPU: 16-bit instructions, 4-cycle FETCH/DECODE/EXECUTE/WRITEBACK,
// run/step gating, zero flag, conditional jump, sticky illegal flag and retired-instruction count.
//
// state     | meaning
// FETCH     | wait for run/step, latch instruction word into IR
// DECODE    | read rs1/rs2 operands
// EXECUTE   | compute result, next pc and flags; HALT leaves for FINISH
// WRITEBACK | commit rd, zero flag, pc, illegal and instr_count together
// FINISH    | halted until reset

module cpu_core_param #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 8,
    parameter int PC_W     = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       run,
    input  logic                       step,
    output logic [PC_W-1:0]            instr_addr,
    input  logic [15:0]                instr_data,
    output logic [2:0]                 cpu_state,
    output logic [DATA_W*NUM_REGS-1:0] reg_file_out,
    output logic [PC_W-1:0]            pc,
    output logic                       zero_flag,
    output logic [15:0]                instr_count,
    output logic                       halted,
    output logic                       illegal
);

    localparam int IDX_W = $clog2(NUM_REGS);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_WRITEBACK = 3'd3,
        S_FINISH    = 3'd4
    } state_t;

    state_t            state;
    logic [15:0]       ir;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] op_a, op_b;
    logic [DATA_W-1:0] res_q;
    logic [PC_W-1:0]   pc_q;
    logic              wr_q, zupd_q, ill_q;

    logic [DATA_W-1:0] alu_res;
    logic [PC_W-1:0]   alu_pc;
    logic              alu_wr, alu_zupd, alu_ill;
    logic              rd_ok, rs1_ok, rs2_ok;

    // Range checks use the whole 4-bit field so that e.g. r7 never aliases onto r3 when NUM_REGS=4.
    assign rd_ok  = int'(ir[11:8]) < NUM_REGS;
    assign rs1_ok = int'(ir[7:4])  < NUM_REGS;
    assign rs2_ok = int'(ir[3:0])  < NUM_REGS;

    assign instr_addr = pc;
    assign cpu_state  = state;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_rf_out
        assign reg_file_out[g*DATA_W +: DATA_W] = regs[g];
    end

    always_comb begin
        alu_res  = '0;
        alu_wr   = 1'b0;
        alu_zupd = 1'b0;
        alu_ill  = 1'b0;
        alu_pc   = pc + PC_W'(1);
        case (ir[15:12])
            4'h1: begin alu_res = DATA_W'(ir[7:0]); alu_wr = 1'b1; end
            4'h2: begin alu_res = op_a;             alu_wr = 1'b1; end
            4'h3: begin alu_res = op_a + op_b;      alu_wr = 1'b1; alu_zupd = 1'b1; end
            4'h4: begin alu_res = op_a - op_b;      alu_wr = 1'b1; alu_zupd = 1'b1; end
            4'h5: begin alu_res = op_a & op_b;      alu_wr = 1'b1; alu_zupd = 1'b1; end
            4'h6: begin alu_res = op_a | op_b;      alu_wr = 1'b1; alu_zupd = 1'b1; end
            4'h7: begin alu_res = op_a ^ op_b;      alu_wr = 1'b1; alu_zupd = 1'b1; end
            4'h8: alu_pc = ir[PC_W-1:0];
            4'h9: if (zero_flag) alu_pc = ir[PC_W-1:0];
            4'hA, 4'hB, 4'hC, 4'hD, 4'hE: alu_ill = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_FETCH;
            pc          <= '0;
            ir          <= '0;
            op_a        <= '0;
            op_b        <= '0;
            res_q       <= '0;
            pc_q        <= '0;
            wr_q        <= 1'b0;
            zupd_q      <= 1'b0;
            ill_q       <= 1'b0;
            zero_flag   <= 1'b0;
            instr_count <= '0;
            halted      <= 1'b0;
            illegal     <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (run || step) begin
                        ir    <= instr_data;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    op_a  <= rs1_ok ? regs[ir[4 +: IDX_W]] : '0;
                    op_b  <= rs2_ok ? regs[ir[0 +: IDX_W]] : '0;
                    state <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    res_q  <= alu_res;
                    pc_q   <= alu_pc;
                    wr_q   <= alu_wr;
                    zupd_q <= alu_zupd;
                    ill_q  <= alu_ill;
                    if (ir[15:12] == 4'hF) begin
                        state  <= S_FINISH;
                        halted <= 1'b1;
                    end else begin
                        state <= S_WRITEBACK;
                    end
                end
                S_WRITEBACK: begin
                    if (wr_q && rd_ok) regs[ir[8 +: IDX_W]] <= res_q;
                    if (zupd_q) zero_flag <= (res_q == '0);
                    if (ill_q) illegal <= 1'b1;
                    if (instr_count != 16'hFFFF) instr_count <= instr_count + 16'd1;
                    pc    <= pc_q;
                    state <= S_FETCH;
                end
                S_FINISH: state <= S_FINISH;
                default:  state <= S_FETCH;
            endcase
        end
    end

endmodule
